// File: rtl/caf_pkg.sv
// Shared definitions for the correlator peak search: state encoding and
// the magnitude width derivation.
package caf_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2
    } peak_state_e;

    // i*i + q*q of two full-scale signed values needs twice the wider input width.
    function automatic int mag_width(input int a_bits, input int b_bits);
        return 2 * ((a_bits > b_bits) ? a_bits : b_bits);
    endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// Two-stage registered squared magnitude: stage 1 squares i and q,
// stage 2 sums them into an unsigned word wide enough never to wrap.
module cpx_mag_sq #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int mag_bits = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic signed [i_bits-1:0]   i,
    input  logic signed [q_bits-1:0]   q,
    output logic                       valid_o,
    output logic [mag_bits-1:0]        mag_o
);

    logic signed [2*i_bits-1:0] i_sx;
    logic signed [2*q_bits-1:0] q_sx;
    logic [2*i_bits-1:0]        ii_d, ii_q;
    logic [2*q_bits-1:0]        qq_d, qq_q;
    logic [mag_bits-1:0]        mag_d, mag_q;
    logic                       sq_vld_q, mag_vld_q;

    assign i_sx  = (2*i_bits)'(i);
    assign q_sx  = (2*q_bits)'(q);
    assign ii_d  = $unsigned(i_sx * i_sx);
    assign qq_d  = $unsigned(q_sx * q_sx);
    assign mag_d = mag_bits'(ii_q) + mag_bits'(qq_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_vld_q  <= 1'b0;
            mag_vld_q <= 1'b0;
            ii_q      <= '0;
            qq_q      <= '0;
            mag_q     <= '0;
        end else begin
            sq_vld_q  <= valid_i;
            mag_vld_q <= sq_vld_q;
            if (valid_i) begin
                ii_q <= ii_d;
                qq_q <= qq_d;
            end
            if (sq_vld_q) begin
                mag_q <= mag_d;
            end
        end
    end

    assign valid_o = mag_vld_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/corr_peak_search.sv
// Finds the largest |i+jq|^2 and its zero-based position in each frame of
// frame_len accepted products; the result is held until downstream takes it.
module corr_peak_search
    import caf_pkg::*;
#(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int frame_len  = 16,
    parameter int index_bits = 4,
    parameter int mag_bits   = mag_width(i_bits, q_bits)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_axis_product_tvalid,
    output logic                     s_axis_product_tready,
    input  logic signed [i_bits-1:0] i,
    input  logic signed [q_bits-1:0] q,
    output logic                     s_axis_peak_tvalid,
    input  logic                     m_axis_peak_tready,
    output logic [mag_bits-1:0]      peak_mag,
    output logic [index_bits-1:0]    peak_index
);

    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(frame_len - 1);

    peak_state_e             state_q, state_d;
    logic [index_bits-1:0]   cnt_q, cnt_d;
    logic [index_bits-1:0]   idx1_q, idx2_q;
    logic [mag_bits-1:0]     peak_mag_q, mag;
    logic [index_bits-1:0]   peak_index_q;
    logic                    accept, mag_vld, peak_upd;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    assign s_axis_product_tready = (state_q == ST_SEARCH) && !reset;
    assign s_axis_peak_tvalid    = (state_q == ST_HOLD);
    assign accept                = m_axis_product_tvalid && s_axis_product_tready;

    cpx_mag_sq #(
        .i_bits  (i_bits),
        .q_bits  (q_bits),
        .mag_bits(mag_bits)
    ) u_mag (
        .clk    (clk),
        .reset  (reset),
        .valid_i(accept),
        .i      (i),
        .q      (q),
        .valid_o(mag_vld),
        .mag_o  (mag)
    );

    // Index 0 always loads so a new frame never compares against a stale peak.
    assign peak_upd = mag_vld && ((idx2_q == '0) || (mag > peak_mag_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (accept) begin
                    cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (mag_vld && (idx2_q == LAST_IDX)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_axis_peak_tready) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // The index tag shadows the two magnitude stages so it lands with its sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            cnt_q        <= '0;
            idx1_q       <= '0;
            idx2_q       <= '0;
            peak_mag_q   <= '0;
            peak_index_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx2_q  <= idx1_q;
            if (accept) begin
                idx1_q <= cnt_q;
            end
            if (peak_upd) begin
                peak_mag_q   <= mag;
                peak_index_q <= idx2_q;
            end
        end
    end

    assign peak_mag   = peak_mag_q;
    assign peak_index = peak_index_q;

endmodule

// File: tb/tb_corr_peak_search.sv
// Bench for corr_peak_search with frame_len=4: table of frames, expected
// peaks queued at drive time and checked at the output handshake.
module tb_corr_peak_search;

    localparam int FL = 4;
    localparam int IB = 2;
    localparam int MB = 48;
    localparam int W  = MB + IB;

    logic                clk;
    logic                reset;
    logic                m_axis_product_tvalid;
    logic                s_axis_product_tready;
    logic signed [23:0]  i;
    logic signed [23:0]  q;
    logic                s_axis_peak_tvalid;
    logic                m_axis_peak_tready;
    logic [MB-1:0]       peak_mag;
    logic [IB-1:0]       peak_index;

    int n_checks;
    int n_fail;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [3:0][23:0] iv;
        logic [3:0][23:0] qv;
        logic [MB-1:0]    mag;
        logic [IB-1:0]    idx;
        int               gaps;
        int               hold;
    } vec_t;

    vec_t vecs[6];

    corr_peak_search #(
        .i_bits    (24),
        .q_bits    (24),
        .frame_len (FL),
        .index_bits(IB),
        .mag_bits  (MB)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .m_axis_product_tvalid(m_axis_product_tvalid),
        .s_axis_product_tready(s_axis_product_tready),
        .i                    (i),
        .q                    (q),
        .s_axis_peak_tvalid   (s_axis_peak_tvalid),
        .m_axis_peak_tready   (m_axis_peak_tready),
        .peak_mag             (peak_mag),
        .peak_index           (peak_index)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0][23:0] p4(input int a, input int b, input int c, input int d);
        logic [3:0][23:0] r;
        r[0] = a[23:0];
        r[1] = b[23:0];
        r[2] = c[23:0];
        r[3] = d[23:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: all start and end on a falling edge
    task automatic put_product(input logic [23:0] pi, input logic [23:0] pq, input int gaps);
        if (gaps != 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        i = pi;
        q = pq;
        m_axis_product_tvalid = 1'b1;
        check("tready_at_accept", 64'(s_axis_product_tready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        m_axis_product_tvalid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        exp_q.push_back({v.mag, v.idx});
        for (int k = 0; k < FL; k++) begin
            put_product(v.iv[k], v.qv[k], v.gaps);
        end
        check("peak_valid_after_e0", 64'(s_axis_peak_tvalid), 64'd0);
        check("drain_tready_1", 64'(s_axis_product_tready), 64'd0);
        @(negedge clk);
        check("peak_valid_after_e1", 64'(s_axis_peak_tvalid), 64'd0);
        check("drain_tready_2", 64'(s_axis_product_tready), 64'd0);
        @(negedge clk);
        check("peak_valid_after_e2", 64'(s_axis_peak_tvalid), 64'd1);
    endtask

    task automatic get_result(input int hold);
        int            budget;
        logic [MB-1:0] snap_mag;
        logic [IB-1:0] snap_idx;
        logic [W-1:0]  exp;
        budget = 0;
        while (!s_axis_peak_tvalid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!s_axis_peak_tvalid) begin
            check("peak_valid_timeout", 64'(s_axis_peak_tvalid), 64'd1);
            return;
        end
        snap_mag = peak_mag;
        snap_idx = peak_index;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_mag_stable", 64'(peak_mag), 64'(snap_mag));
            check("hold_idx_stable", 64'(peak_index), 64'(snap_idx));
            check("hold_product_tready", 64'(s_axis_product_tready), 64'd0);
            check("hold_peak_tvalid", 64'(s_axis_peak_tvalid), 64'd1);
        end
        // scoreboard
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check("peak_mag", 64'(peak_mag), 64'(exp[W-1:IB]));
            check("peak_index", 64'(peak_index), 64'(exp[IB-1:0]));
        end
        m_axis_peak_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axis_peak_tready = 1'b0;
        check("handshake_clears_valid", 64'(s_axis_peak_tvalid), 64'd0);
        check("handshake_tready_back", 64'(s_axis_product_tready), 64'd1);
    endtask

    initial begin
        vec_t rv;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        m_axis_product_tvalid = 1'b0;
        m_axis_peak_tready = 1'b0;
        i = '0;
        q = '0;

        vecs[0] = '{iv: p4(3, 0, -5, 1), qv: p4(4, 0, 12, 1), mag: 48'd169, idx: 2'd2, gaps: 0, hold: 0};
        vecs[1] = '{iv: p4(3, 4, 0, 5), qv: p4(4, 3, 5, 0), mag: 48'd25, idx: 2'd0, gaps: 0, hold: 0};
        vecs[2] = '{iv: p4(1, 1, 1, -8388608), qv: p4(0, 0, 0, -8388608),
                    mag: 48'd140737488355328, idx: 2'd3, gaps: 0, hold: 0};
        vecs[3] = '{iv: p4(3, 0, -5, 1), qv: p4(4, 0, 12, 1), mag: 48'd169, idx: 2'd2, gaps: 1, hold: 0};
        vecs[4] = '{iv: p4(3, 0, -5, 1), qv: p4(4, 0, 12, 1), mag: 48'd169, idx: 2'd2, gaps: 0, hold: 5};
        vecs[5] = '{iv: p4(1, 2, 0, 0), qv: p4(0, 0, 0, 0), mag: 48'd4, idx: 2'd1, gaps: 0, hold: 0};

        // reset state; a valid product during reset must not be taken
        @(negedge clk);
        m_axis_product_tvalid = 1'b1;
        @(negedge clk);
        check("reset_product_tready", 64'(s_axis_product_tready), 64'd0);
        check("reset_peak_tvalid", 64'(s_axis_peak_tvalid), 64'd0);
        check("reset_peak_mag", 64'(peak_mag), 64'd0);
        check("reset_peak_index", 64'(peak_index), 64'd0);
        m_axis_product_tvalid = 1'b0;
        reset = 1'b0;
        #1;
        check("tready_after_release", 64'(s_axis_product_tready), 64'd1);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v]);
            get_result(vecs[v].hold);
        end

        // reset mid-frame discards the partial frame
        put_product(24'd9, 24'd9, 0);
        put_product(24'd9, 24'd9, 0);
        reset = 1'b1;
        #1;
        check("async_reset_peak_mag", 64'(peak_mag), 64'd0);
        check("async_reset_tready", 64'(s_axis_product_tready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset_tready", 64'(s_axis_product_tready), 64'd1);
        repeat (3) @(negedge clk);
        check("mid_reset_no_result", 64'(s_axis_peak_tvalid), 64'd0);
        check("mid_reset_peak_cleared", 64'(peak_mag), 64'd0);
        rv = '{iv: p4(1, 2, 3, 0), qv: p4(0, 0, 0, 0), mag: 48'd9, idx: 2'd2, gaps: 0, hold: 0};
        send_frame(rv);
        get_result(0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
